// File: rtl/txll_tx_sched.sv
// SATA link-layer TX frame scheduler: waits for a complete frame in the FIFO, streams it to the link,
// flushes overlength frames and reports frame status. Optional watchdog: define TXLL_SCHED_TIMEOUT_EN.
module txll_tx_sched #(
  parameter int unsigned C_MAX_WORDS = 2049,
  parameter int unsigned C_TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] fifo_do,
  input  logic        fifo_empty,
  input  logic        fifo_eof_rdy,
  output logic        fifo_rd_en,
  output logic        ll_req,
  input  logic        ll_gnt,
  output logic [31:0] ll_data,
  output logic        ll_sof,
  output logic        ll_eof,
  output logic        ll_valid,
  input  logic        ll_ready,
  input  logic        ll_done,
  input  logic        ll_err,
  output logic        sts_done,
  output logic        sts_err,
  output logic [11:0] sts_words,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_FLUSH, S_WAIT_ST} state_t;

  localparam logic [11:0] MAX_LAST = 12'(C_MAX_WORDS - 1);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        ovl_q, ovl_d;
  logic        from_xfer_q, from_xfer_d;
  logic        ll_req_q, ll_req_d;
  logic        busy_q, busy_d;
  logic        sts_done_q, sts_done_d;
  logic        sts_err_q, sts_err_d;
  logic [11:0] sts_words_q, sts_words_d;
  logic        wdog_exp;
  logic        head_eof;
  logic        force_eof;
  logic        unused_bits;

  assign head_eof    = fifo_do[34];
  assign force_eof   = (cnt_q == MAX_LAST);
  assign unused_bits = ^{fifo_do[35], fifo_do[33:32]};

`ifdef TXLL_SCHED_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(C_TIMEOUT - 1);
  logic [15:0] wdog_q, wdog_d;

  assign wdog_exp = (wdog_q == WDOG_LAST);

  // Reloads on every state change, counts only while waiting on the link.
  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (state_q == S_REQ || state_q == S_WAIT_ST) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  localparam int unsigned unused_timeout = C_TIMEOUT;
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovl_d       = ovl_q;
    from_xfer_d = from_xfer_q;
    sts_done_d  = 1'b0;
    sts_err_d   = sts_err_q;
    sts_words_d = sts_words_q;
    ll_valid    = 1'b0;
    ll_data     = '0;
    ll_sof      = 1'b0;
    ll_eof      = 1'b0;
    fifo_rd_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d       = '0;
        ovl_d       = 1'b0;
        from_xfer_d = 1'b0;
        if (fifo_eof_rdy && !fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (ll_gnt) begin
          state_d = S_XFER;
        end else if (wdog_exp) begin
          state_d     = S_FLUSH;
          from_xfer_d = 1'b0;
        end
      end
      S_XFER: begin
        ll_valid   = !fifo_empty;
        ll_data    = fifo_do[31:0];
        ll_sof     = ll_valid && (cnt_q == 12'd0);
        ll_eof     = ll_valid && (head_eof || force_eof);
        fifo_rd_en = ll_valid && ll_ready;
        if (fifo_rd_en) begin
          cnt_d = cnt_q + 12'd1;
          if (head_eof) begin
            state_d = S_WAIT_ST;
          end else if (force_eof) begin
            // Link already saw EOF; drain the rest of the frame from the FIFO.
            ovl_d       = 1'b1;
            from_xfer_d = 1'b1;
            state_d     = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_rd_en && head_eof) begin
          if (from_xfer_q) begin
            state_d = S_WAIT_ST;
          end else begin
            state_d     = S_IDLE;
            sts_done_d  = 1'b1;
            sts_err_d   = 1'b1;
            sts_words_d = cnt_q;
          end
        end
      end
      S_WAIT_ST: begin
        if (ll_done) begin
          state_d     = S_IDLE;
          sts_done_d  = 1'b1;
          sts_err_d   = ll_err | ovl_q;
          sts_words_d = cnt_q;
        end else if (wdog_exp) begin
          state_d     = S_IDLE;
          sts_done_d  = 1'b1;
          sts_err_d   = 1'b1;
          sts_words_d = cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ll_req_d = (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ovl_q       <= 1'b0;
      from_xfer_q <= 1'b0;
      ll_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      sts_done_q  <= 1'b0;
      sts_err_q   <= 1'b0;
      sts_words_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovl_q       <= ovl_d;
      from_xfer_q <= from_xfer_d;
      ll_req_q    <= ll_req_d;
      busy_q      <= busy_d;
      sts_done_q  <= sts_done_d;
      sts_err_q   <= sts_err_d;
      sts_words_q <= sts_words_d;
    end
  end

  assign ll_req    = ll_req_q;
  assign busy      = busy_q;
  assign sts_done  = sts_done_q;
  assign sts_err   = sts_err_q;
  assign sts_words = sts_words_q;

endmodule

// File: tb/tb_txll_tx_sched.sv
// Scoreboard bench for txll_tx_sched: FIFO model, link responder, and a monitor checking dwords and status.
module tb_txll_tx_sched;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] fifo_do;
  logic        fifo_empty, fifo_eof_rdy, fifo_rd_en;
  logic        ll_req, ll_gnt = 1'b0;
  logic [31:0] ll_data;
  logic        ll_sof, ll_eof, ll_valid;
  logic        ll_ready = 1'b1;
  logic        ll_done = 1'b0, ll_err = 1'b0;
  logic        sts_done, sts_err, busy;
  logic [11:0] sts_words;

  logic [35:0] mem [0:255];
  int          wr_ptr = 0, rd_ptr = 0, eof_wr = 0, eof_rd = 0;

  logic [33:0] exp_q [$];
  logic [12:0] sts_q [$];
  logic        err_q [$];

  int vectors = 0, miscompares = 0;
  int pops = 0, sts_seen = 0;
  int ready_mode = 0;
  bit gnt_en = 1'b1, mon_skip = 1'b0;

  txll_tx_sched #(.C_MAX_WORDS(MAXW), .C_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fifo_do(fifo_do), .fifo_empty(fifo_empty),
    .fifo_eof_rdy(fifo_eof_rdy), .fifo_rd_en(fifo_rd_en), .ll_req(ll_req),
    .ll_gnt(ll_gnt), .ll_data(ll_data), .ll_sof(ll_sof), .ll_eof(ll_eof),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_done(ll_done), .ll_err(ll_err),
    .sts_done(sts_done), .sts_err(sts_err), .sts_words(sts_words), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  assign fifo_do      = mem[rd_ptr[7:0]];
  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_eof_rdy = (eof_wr != eof_rd);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO read side; reset discards its contents.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      rd_ptr <= wr_ptr;
      eof_rd <= eof_wr;
    end else if (fifo_rd_en) begin
      if (mem[rd_ptr[7:0]][34]) eof_rd <= eof_rd + 1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Link responder: grant 3 cycles into ll_req, status 3 cycles after the EOF dword.
  initial begin
    int  req_cyc  = 0;
    int  done_dly = 0;
    bit  acc_eof, req_now;
    forever begin
      @(negedge clk);
      acc_eof = ll_valid && ll_ready && ll_eof;
      req_now = ll_req;
      @(posedge clk);
      #1;
      ll_gnt  = 1'b0;
      ll_done = 1'b0;
      ll_err  = 1'b0;
      case (ready_mode)
        1:       ll_ready = ~ll_ready;
        2:       ll_ready = 1'b0;
        default: ll_ready = 1'b1;
      endcase
      if (req_now) begin
        req_cyc++;
        if (req_cyc == 3 && gnt_en) ll_gnt = 1'b1;
      end else begin
        req_cyc = 0;
      end
      if (acc_eof) begin
        done_dly = 3;
      end else if (done_dly > 0) begin
        done_dly--;
        if (done_dly == 0) begin
          ll_done = 1'b1;
          ll_err  = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
        end
      end
    end
  end

  // Monitor: compares every presented dword and every status pulse against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (fifo_rd_en) pops++;
    if (ll_valid && !mon_skip) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dword", {ll_sof, ll_eof, ll_data}, 34'h0);
      end else begin
        chk(ll_ready ? "dword" : "dword_hold", {ll_sof, ll_eof, ll_data}, exp_q[0]);
        if (ll_ready) void'(exp_q.pop_front());
      end
    end
    if (sts_done) begin
      sts_seen++;
      if (sts_q.size() == 0) chk("unexpected_sts", {sts_err, sts_words}, 13'h0);
      else                   chk("sts", {sts_err, sts_words}, sts_q.pop_front());
    end
  end

  task automatic push_frame(input int n, input logic [31:0] base, input bit with_exp);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = {1'b0, (i == n - 1), 2'b00, base + 32'(i)};
      wr_ptr++;
      if (with_exp && i < MAXW)
        exp_q.push_back({(i == 0), (i == n - 1) || (i == MAXW - 1), base + 32'(i)});
    end
    eof_wr++;
  endtask

  task automatic wait_sts(input int target, input string name);
    for (int i = 0; i < 400 && sts_seen < target; i++) @(posedge clk);
    #1;
    chk({name, "_sts_count"}, sts_seen, target);
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   ll_req, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_valid", ll_valid, 0);
    chk("rst_rden",  fifo_rd_en, 0);
    chk("rst_sts",   {sts_done, sts_err, sts_words}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4-dword frame, link always ready
    p0 = pops;
    push_frame(4, 32'hA000_0000, 1'b1);
    err_q.push_back(1'b0);
    sts_q.push_back({1'b0, 12'd4});
    wait_sts(1, "t1");
    chk("t1_pops", pops - p0, 4);

    // same frame shape, ready toggling
    ready_mode = 1;
    p0 = pops;
    push_frame(4, 32'hB000_0010, 1'b1);
    err_q.push_back(1'b0);
    sts_q.push_back({1'b0, 12'd4});
    wait_sts(2, "t2");
    chk("t2_pops", pops - p0, 4);
    ready_mode = 0;

    // overlength: 10 dwords, cut at 8, 2 flushed
    p0 = pops;
    push_frame(10, 32'hC000_0100, 1'b1);
    err_q.push_back(1'b0);
    sts_q.push_back({1'b1, 12'd8});
    wait_sts(3, "t3");
    chk("t3_pops", pops - p0, 10);

    // back-to-back 1- and 2-dword frames, second with link error
    p0 = pops;
    push_frame(1, 32'hD000_0200, 1'b1);
    push_frame(2, 32'hE000_0300, 1'b1);
    err_q.push_back(1'b0);
    err_q.push_back(1'b1);
    sts_q.push_back({1'b0, 12'd1});
    sts_q.push_back({1'b1, 12'd2});
    wait_sts(5, "t4");
    chk("t4_pops", pops - p0, 3);

`ifdef TXLL_SCHED_TIMEOUT_EN
    // grant never comes: watchdog drops the frame
    gnt_en = 1'b0;
    p0 = pops;
    push_frame(3, 32'hF000_0400, 1'b0);
    sts_q.push_back({1'b1, 12'd0});
    wait_sts(6, "t5");
    chk("t5_pops", pops - p0, 3);
    chk("t5_fifo_empty", fifo_empty, 1);
    gnt_en = 1'b1;
`endif

    // reset while a dword is presented and stalled
    ready_mode = 2;
    mon_skip   = 1'b1;
    push_frame(6, 32'h1234_5600, 1'b0);
    for (int i = 0; i < 50 && !ll_valid; i++) @(posedge clk);
    #3;
    chk("t6_valid_before", {ll_valid, ll_sof, ll_data}, {2'b11, 32'h1234_5600});
    rst = 1'b1;
    #1;
    chk("t6_valid_rst", ll_valid, 0);
    chk("t6_outs_rst", {ll_sof, ll_eof, fifo_rd_en, ll_data}, 0);
    @(posedge clk);
    #1;
    chk("t6_regs_rst", {ll_req, busy, sts_done}, 0);
    rst = 1'b0;
    ready_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_idle_after", {busy, ll_req, ll_valid}, 0);
    mon_skip = 1'b0;

    chk("exp_q_drained", exp_q.size(), 0);
    chk("sts_q_drained", sts_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
